// File: rtl/wn_skid_buffer.sv
// wn_skid_buffer: two-entry AXI-Stream register slice with fully registered outputs
module wn_skid_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int USER_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  input_tvalid,
    output logic                  input_tready,
    input  logic [DATA_WIDTH-1:0] input_tdata,
    input  logic [USER_WIDTH-1:0] input_tuser,
    input  logic                  input_tlast,
    output logic                  output_tvalid,
    input  logic                  output_tready,
    output logic [DATA_WIDTH-1:0] output_tdata,
    output logic [USER_WIDTH-1:0] output_tuser,
    output logic                  output_tlast
);
    localparam int W = DATA_WIDTH + USER_WIDTH + 1;
    // bit 0 is output_tvalid, bit 1 is skid_valid, so both come straight from flops
    typedef enum logic [1:0] {EMPTY = 2'b00, BUSY = 2'b01, FULL = 2'b11} state_t;
    state_t state_q, state_d;
    logic [W-1:0] out_q, out_d, skid_q, skid_d, in_beat;
    logic in_ready_q, in_ready_d, accept, pop;
    assign in_beat = {input_tdata, input_tuser, input_tlast};
    assign accept = input_tvalid & in_ready_q;
    assign pop = state_q[0] & output_tready;
    always_comb begin
        state_d = state_q;
        out_d = out_q;
        skid_d = skid_q;
        case (state_q)
            EMPTY: if (accept) begin
                out_d = in_beat;
                state_d = BUSY;
            end
            BUSY: if (accept && pop) out_d = in_beat;
                else if (accept) begin
                    skid_d = in_beat;
                    state_d = FULL;
                end else if (pop) state_d = EMPTY;
            FULL: if (pop) begin
                out_d = skid_q;
                state_d = BUSY;
            end
            default: state_d = EMPTY;
        endcase
        in_ready_d = !state_d[1];
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= EMPTY;
            out_q <= '0;
            skid_q <= '0;
            in_ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q <= out_d;
            skid_q <= skid_d;
            in_ready_q <= in_ready_d;
        end
    end
    assign input_tready = in_ready_q;
    assign output_tvalid = state_q[0];
    assign {output_tdata, output_tuser, output_tlast} = out_q;
endmodule

// File: tb/tb_wn_skid_buffer.sv
// tb_wn_skid_buffer: random and directed stimulus checked against a queue model of the slice
module tb_wn_skid_buffer;
    logic clock = 1'b0, reset = 1'b1;
    logic input_tvalid = 1'b0, input_tready, input_tlast = 1'b0;
    logic [7:0] input_tdata = '0, input_tuser = '0;
    logic output_tvalid, output_tready = 1'b0, output_tlast;
    logic [7:0] output_tdata, output_tuser;
    int n_cmp = 0, n_bad = 0;
    logic [16:0] q[$];
    logic m_ready = 1'b0;
    wn_skid_buffer #(.DATA_WIDTH(8), .USER_WIDTH(8)) dut (
        .clock(clock), .reset(reset),
        .input_tvalid(input_tvalid), .input_tready(input_tready),
        .input_tdata(input_tdata), .input_tuser(input_tuser), .input_tlast(input_tlast),
        .output_tvalid(output_tvalid), .output_tready(output_tready),
        .output_tdata(output_tdata), .output_tuser(output_tuser), .output_tlast(output_tlast)
    );
    always #5 clock = ~clock;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask
    // one clock: drive inputs, advance the queue model, compare after the edge
    task automatic step(input logic v, input logic [7:0] d, input logic [7:0] u, input logic l,
                        input logic ordy, input logic rst);
        logic acc, pp;
        reset = rst;
        input_tvalid = v;
        input_tdata = d;
        input_tuser = u;
        input_tlast = l;
        output_tready = ordy;
        acc = v & m_ready & !rst;
        pp = (q.size() > 0) & ordy & !rst;
        @(posedge clock);
        #1;
        if (rst) begin
            q.delete();
            m_ready = 1'b0;
        end else begin
            if (pp) void'(q.pop_front());
            if (acc) q.push_back({d, u, l});
            m_ready = q.size() < 2;
        end
        chk("input_tready", 32'(input_tready), 32'(m_ready));
        chk("output_tvalid", 32'(output_tvalid), 32'(q.size() > 0));
        if (q.size() > 0) begin
            chk("output_tdata", 32'(output_tdata), 32'(q[0][16:9]));
            chk("output_tuser", 32'(output_tuser), 32'(q[0][8:1]));
            chk("output_tlast", 32'(output_tlast), 32'(q[0][0]));
        end else if (rst) begin
            chk("reset_payload", {15'd0, output_tdata, output_tuser, output_tlast}, 32'd0);
        end
    endtask
    initial begin
        for (int i = 0; i < 10; i++) step(1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 8'd0, 8'd0, 1'b0, 1'b1, 1'b0);
        chk("ready_after_release", 32'(input_tready), 32'd1);
        for (int i = 10; i < 14; i++) step(1'b1, 8'(i), 8'(i), 1'b0, 1'b1, 1'b0);
        step(1'b0, 8'd0, 8'd0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 8'd14, 8'h44, 1'b0, 1'b1, 1'b0);
        step(1'b1, 8'd15, 8'h55, 1'b0, 1'b0, 1'b0);
        chk("bp_ready_low", 32'(input_tready), 32'd0);
        step(1'b1, 8'd99, 8'h99, 1'b0, 1'b0, 1'b0);
        chk("bp_hold_14", 32'(output_tdata), 32'd14);
        step(1'b0, 8'd0, 8'd0, 1'b0, 1'b1, 1'b0);
        chk("bp_then_15", 32'(output_tdata), 32'd15);
        step(1'b0, 8'd0, 8'd0, 1'b0, 1'b1, 1'b0);
        chk("bp_ready_back", 32'(input_tready), 32'd1);
        for (int i = 16; i < 24; i++)
            step(1'b1, 8'(i), 8'($urandom), i == 17, 1'b1, 1'b0);
        step(1'b0, 8'd0, 8'd0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 8'd30, 8'd1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'd31, 8'd2, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1);
        chk("flush_valid", 32'(output_tvalid), 32'd0);
        for (int i = 0; i < 10; i++) step(1'b0, 8'd0, 8'd0, 1'b0, 1'(i & 1), 1'b0);
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom), 1'($urandom),
                 $urandom_range(0, 2) != 0, $urandom_range(0, 99) == 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
